ofdm_symbol_pingpong: RTL and testbench

Double-buffered I/Q symbol store for the OFDM datapath. Samples are written in natural order, one complete symbol per bank, and read back with valid/ready backpressure. The read side can optionally emit a cyclic prefix and apply a bit-reversed read order. The block sits between the FFT/IFFT core and the framing/DAC stage, so one symbol can be filled while the previous one drains.

---
 rtl/ofdm_symbol_pingpong.sv | 174 +++++++++++++++++
 tb/tb_ofdm_symbol_pingpong.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_pingpong.sv
// rtl/ofdm_symbol_pingpong.sv - double-buffered I/Q symbol store with optional cyclic prefix and bit-reversed readout
// One bank fills in natural order while the other drains through a valid/ready output register.
module ofdm_symbol_pingpong #(
  parameter int ADDR_SIZE   = 6,
  parameter int DATA_SIZE   = 16,
  parameter int CP_LEN      = 0,
  parameter int READ_BITREV = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_i,
  input  logic [DATA_SIZE-1:0] in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_i,
  output logic [DATA_SIZE-1:0] out_q,
  output logic                 out_cp,
  output logic                 out_last,
  output logic [1:0]           bank_full
);

  localparam int N = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(N - 1);
  localparam logic [ADDR_SIZE-1:0] CP_MOD    = ADDR_SIZE'(CP_LEN);
  localparam logic [ADDR_SIZE:0]   CNT_END   = (ADDR_SIZE+1)'(CP_LEN + N);
  localparam logic [ADDR_SIZE:0]   CNT_LAST  = (ADDR_SIZE+1)'(CP_LEN + N - 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } rd_state_t;

  logic [DATA_SIZE-1:0] mem_i [2*N];
  logic [DATA_SIZE-1:0] mem_q [2*N];

  logic                 wr_bank;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 wr_fire;
  logic                 wr_done;

  logic                 rd_bank;
  logic [ADDR_SIZE:0]   rd_cnt;
  logic                 rd_issue;
  logic                 last_accept;
  logic [ADDR_SIZE-1:0] log_idx;
  logic [ADDR_SIZE-1:0] phys_addr;
  logic                 in_prefix;
  logic [1:0]           bank_full_d;

  rd_state_t state_q;
  rd_state_t state_d;

  assign in_ready    = !bank_full[wr_bank];
  assign wr_fire     = in_valid && in_ready;
  assign wr_done     = wr_fire && (wr_addr == ADDR_LAST);
  assign last_accept = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_i[{wr_bank, wr_addr}] <= in_i;
      mem_q[{wr_bank, wr_addr}] <= in_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (wr_fire) begin
      wr_addr <= wr_addr + ADDR_SIZE'(1);
      if (wr_done) begin
        wr_bank <= !wr_bank;
      end
    end
  end

  // The writer only touches a non-full bank and the reader only a full one, so both updates can land together.
  always_comb begin
    bank_full_d = bank_full;
    if (wr_done) begin
      bank_full_d[wr_bank] = 1'b1;
    end
    if (last_accept) begin
      bank_full_d[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bank_full[rd_bank]) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_issue = (rd_cnt < CNT_END) && (!out_valid || out_ready);
        if (last_accept) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rd_cnt <= rd_cnt + (ADDR_SIZE+1)'(1);
      end
      if (last_accept) begin
        rd_bank <= !rd_bank;
      end
    end
  end

  // Prefix samples map to N-CP_LEN+cnt, which is the same as cnt-CP_LEN modulo N.
  assign log_idx = rd_cnt[ADDR_SIZE-1:0] - CP_MOD;

  generate
    if (READ_BITREV != 0) begin : g_rev
      for (genvar b = 0; b < ADDR_SIZE; b++) begin : g_bit
        assign phys_addr[b] = log_idx[ADDR_SIZE-1-b];
      end
    end else begin : g_nat
      assign phys_addr = log_idx;
    end
  endgenerate

  generate
    if (CP_LEN > 0) begin : g_cp
      assign in_prefix = (rd_cnt < (ADDR_SIZE+1)'(CP_LEN));
    end else begin : g_no_cp
      assign in_prefix = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_cp    <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_issue) begin
      out_valid <= 1'b1;
      out_i     <= mem_i[{rd_bank, phys_addr}];
      out_q     <= mem_q[{rd_bank, phys_addr}];
      out_cp    <= in_prefix;
      out_last  <= (rd_cnt == CNT_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofdm_symbol_pingpong.sv
// tb/tb_ofdm_symbol_pingpong.sv - scoreboard bench for plain, cyclic-prefix and bit-reversed configurations
module tb_ofdm_symbol_pingpong;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        cp;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [15:0] i_base;
    logic [15:0] q_base;
    logic [3:0]  rdy;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [15:0] e_c;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        wv;
  logic        in_valid;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        out_ready;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  ocp;
  logic [2:0]  olast;
  logic [15:0] oi [3];
  logic [15:0] oq [3];
  logic [1:0]  bf [3];
  logic        all_rdy;

  logic [3:0]  rdy_pat;
  logic [1:0]  rdy_ph;
  int          cyc;
  int          checks;
  int          failures;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        qc[$];
  logic [15:0] ga[$];
  logic [15:0] gb[$];
  logic [15:0] gc[$];
  logic [15:0] sym_i [8];
  logic [15:0] sym_q [8];
  int          widx;
  int          last_wr_cyc;

  int          first_cyc [3];
  int          run [3];
  int          last_run [3];
  logic [2:0]  prev_ov;
  logic [2:0]  hold_pend;
  logic [15:0] hi [3];
  logic [15:0] hq [3];
  logic [2:0]  hc;
  logic [2:0]  hl;

  vec_t        vec [4];

  assign all_rdy  = &ir;
  assign in_valid = wv & all_rdy;

  ofdm_symbol_pingpong #(.ADDR_SIZE(3), .DATA_SIZE(16), .CP_LEN(0), .READ_BITREV(0)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_i(in_i), .in_q(in_q),
    .out_valid(ov[0]), .out_ready(out_ready), .out_i(oi[0]), .out_q(oq[0]),
    .out_cp(ocp[0]), .out_last(olast[0]), .bank_full(bf[0])
  );

  ofdm_symbol_pingpong #(.ADDR_SIZE(3), .DATA_SIZE(16), .CP_LEN(2), .READ_BITREV(0)) u_cp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_i(in_i), .in_q(in_q),
    .out_valid(ov[1]), .out_ready(out_ready), .out_i(oi[1]), .out_q(oq[1]),
    .out_cp(ocp[1]), .out_last(olast[1]), .bank_full(bf[1])
  );

  ofdm_symbol_pingpong #(.ADDR_SIZE(3), .DATA_SIZE(16), .CP_LEN(0), .READ_BITREV(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_i(in_i), .in_q(in_q),
    .out_valid(ov[2]), .out_ready(out_ready), .out_i(oi[2]), .out_q(oq[2]),
    .out_cp(ocp[2]), .out_last(olast[2]), .bank_full(bf[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    out_ready = 1'b1;
    rdy_ph    = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_pat[rdy_ph];
      rdy_ph    = rdy_ph + 2'd1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=0x%0h expected=0x%0h", nm, k, act, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    case (k)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic exp_t exp_pop(input int k);
    case (k)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  function automatic void got_push(input int k, input logic [15:0] v);
    case (k)
      0:       ga.push_back(v);
      1:       gb.push_back(v);
      default: gc.push_back(v);
    endcase
  endfunction

  function automatic int got_size(input int k);
    case (k)
      0:       return ga.size();
      1:       return gb.size();
      default: return gc.size();
    endcase
  endfunction

  function automatic logic [15:0] got_at(input int k, input int n);
    case (k)
      0:       return ga[n];
      1:       return gb[n];
      default: return gc[n];
    endcase
  endfunction

  // Reference order: natural, cyclic prefix of two, and 3-bit reversed.
  function automatic void push_symbol();
    exp_t       e;
    logic [2:0] jj;
    logic [2:0] rr;
    int         idx;
    for (int j = 0; j < 8; j++) begin
      e = '{i: sym_i[j], q: sym_q[j], cp: 1'b0, last: (j == 7)};
      qa.push_back(e);
    end
    for (int j = 0; j < 10; j++) begin
      idx = (j < 2) ? 6 + j : j - 2;
      e = '{i: sym_i[idx], q: sym_q[idx], cp: (j < 2), last: (j == 9)};
      qb.push_back(e);
    end
    for (int j = 0; j < 8; j++) begin
      jj = 3'(j);
      rr = {jj[0], jj[1], jj[2]};
      e = '{i: sym_i[rr], q: sym_q[rr], cp: 1'b0, last: (j == 7)};
      qc.push_back(e);
    end
  endfunction

  task automatic wr(input logic [15:0] di, input logic [15:0] dq);
    int n;
    n = 0;
    @(negedge clk);
    wv   = 1'b1;
    in_i = di;
    in_q = dq;
    while (!all_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!all_rdy) begin
      chk("in_ready_timeout", 0, 32'(all_rdy), 1);
      wv = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      wv          = 1'b0;
      last_wr_cyc = cyc;
      sym_i[widx] = di;
      sym_q[widx] = dq;
      widx++;
      if (widx == 8) begin
        push_symbol();
        widx = 0;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((qa.size() + qb.size() + qc.size() != 0 || ov != 3'b000) && n < 1000);
    chk("drain_done", 0, 32'(qa.size() + qb.size() + qc.size() == 0 && ov == 3'b000), 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    hold_pend = '0;
    prev_ov   = '0;
    for (int k = 0; k < 3; k++) begin
      run[k]      = 0;
      last_run[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = '0;
        prev_ov   = '0;
        for (int k = 0; k < 3; k++) run[k] = 0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (hold_pend[k]) begin
            chk("hold_valid", k, 32'(ov[k]), 1);
            chk("hold_i", k, 32'(oi[k]), 32'(hi[k]));
            chk("hold_q", k, 32'(oq[k]), 32'(hq[k]));
            chk("hold_cp", k, 32'(ocp[k]), 32'(hc[k]));
            chk("hold_last", k, 32'(olast[k]), 32'(hl[k]));
          end
          hold_pend[k] = ov[k] && !out_ready;
          if (hold_pend[k]) begin
            hi[k] = oi[k];
            hq[k] = oq[k];
            hc[k] = ocp[k];
            hl[k] = olast[k];
          end
          if (ov[k] && out_ready) begin
            if (exp_size(k) == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_out dut%0d got=0x%0h expected=none", k, oi[k]);
            end else begin
              e = exp_pop(k);
              chk("out_i", k, 32'(oi[k]), 32'(e.i));
              chk("out_q", k, 32'(oq[k]), 32'(e.q));
              chk("out_cp", k, 32'(ocp[k]), 32'(e.cp));
              chk("out_last", k, 32'(olast[k]), 32'(e.last));
              got_push(k, oi[k]);
            end
          end
          if (ov[k] && !prev_ov[k] && first_cyc[k] < 0) first_cyc[k] = cyc;
          if (ov[k]) begin
            run[k]++;
          end else begin
            if (prev_ov[k]) last_run[k] = run[k];
            run[k] = 0;
          end
          prev_ov[k] = ov[k];
        end
      end
    end
  end

  initial begin
    int n;
    int e_last;
    checks   = 0;
    failures = 0;
    widx     = 0;
    rst_n    = 1'b0;
    wv       = 1'b0;
    in_i     = '0;
    in_q     = '0;
    rdy_pat  = 4'hF;
    for (int k = 0; k < 3; k++) first_cyc[k] = -1;

    vec[0] = '{16'h0000, 16'd100, 4'b1111, 16'h0001, 16'h0007, 16'h0004};
    vec[1] = '{16'h0010, 16'd200, 4'b1001, 16'h0011, 16'h0017, 16'h0014};
    vec[2] = '{16'h1000, 16'h2000, 4'b0101, 16'h1001, 16'h1007, 16'h1004};
    vec[3] = '{16'hFFF8, 16'h7FF8, 4'b1110, 16'hFFF9, 16'hFFFF, 16'hFFFC};

    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 0);
      chk("rst_in_ready", k, 32'(ir[k]), 1);
      chk("rst_bank_full", k, 32'(bf[k]), 0);
      chk("rst_out_i", k, 32'(oi[k]), 0);
      chk("rst_out_cp", k, 32'(ocp[k]), 0);
      chk("rst_out_last", k, 32'(olast[k]), 0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      rdy_pat = vec[v].rdy;
      ga.delete();
      gb.delete();
      gc.delete();
      for (int k = 0; k < 3; k++) first_cyc[k] = -1;
      for (int j = 0; j < 8; j++) wr(vec[v].i_base + 16'(j), vec[v].q_base + 16'(j));
      e_last = last_wr_cyc;
      wait_drain();
      for (int k = 0; k < 3; k++) begin
        chk("out_count", k, 32'(got_size(k)), (k == 1) ? 10 : 8);
        chk("bank_empty", k, 32'(bf[k]), 0);
      end
      if (got_size(0) >= 2) chk("second_i", 0, 32'(got_at(0, 1)), 32'(vec[v].e_a));
      if (got_size(1) >= 2) chk("second_i", 1, 32'(got_at(1, 1)), 32'(vec[v].e_b));
      if (got_size(2) >= 2) chk("second_i", 2, 32'(got_at(2, 1)), 32'(vec[v].e_c));
      if (v == 0) begin
        for (int k = 0; k < 3; k++) begin
          chk("first_valid_cycle", k, 32'(first_cyc[k]), 32'(e_last + 2));
          chk("valid_run", k, 32'(last_run[k]), (k == 1) ? 10 : 8);
        end
      end
    end

    // Both banks full under stall, then release and watch bank 0 free up.
    rdy_pat = 4'h0;
    @(posedge clk);
    #2;
    for (int j = 0; j < 16; j++) wr(16'h0500 + 16'(j), 16'h0600 + 16'(j));
    for (int k = 0; k < 3; k++) begin
      chk("pp_bank_full", k, 32'(bf[k]), 3);
      chk("pp_in_ready", k, 32'(ir[k]), 0);
    end
    rdy_pat = 4'hF;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(ov[0] && out_ready && olast[0]) && n < 200);
    chk("pp_last_seen", 0, 32'(ov[0] && out_ready && olast[0]), 1);
    chk("pp_ready_before", 0, 32'(ir[0]), 0);
    @(posedge clk);
    #2;
    chk("pp_ready_after", 0, 32'(ir[0]), 1);
    chk("pp_bank_after", 0, 32'(bf[0]), 2);
    wait_drain();

    // Reset during a stalled drain with a partial symbol in the other bank.
    rdy_pat = 4'h0;
    @(posedge clk);
    #2;
    for (int j = 0; j < 8; j++) wr(16'h0A00 + 16'(j), 16'h0A80 + 16'(j));
    for (int j = 0; j < 5; j++) wr(16'h0B00 + 16'(j), 16'h0B80 + 16'(j));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_out_valid", k, 32'(ov[k]), 0);
      chk("mid_rst_out_i", k, 32'(oi[k]), 0);
      chk("mid_rst_out_q", k, 32'(oq[k]), 0);
      chk("mid_rst_out_cp", k, 32'(ocp[k]), 0);
      chk("mid_rst_out_last", k, 32'(olast[k]), 0);
      chk("mid_rst_bank_full", k, 32'(bf[k]), 0);
      chk("mid_rst_in_ready", k, 32'(ir[k]), 1);
    end
    qa.delete();
    qb.delete();
    qc.delete();
    widx    = 0;
    rdy_pat = 4'hF;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ga.delete();
    gb.delete();
    gc.delete();
    for (int j = 0; j < 8; j++) wr(16'h0C00 + 16'(j), 16'h0D00 + 16'(j));
    wait_drain();
    for (int k = 0; k < 3; k++) chk("post_rst_count", k, 32'(got_size(k)), (k == 1) ? 10 : 8);
    if (got_size(0) >= 1) chk("post_rst_first", 0, 32'(got_at(0, 0)), 32'h0C00);
    if (got_size(1) >= 1) chk("post_rst_first", 1, 32'(got_at(1, 0)), 32'h0C06);
    if (got_size(2) >= 1) chk("post_rst_first", 2, 32'(got_at(2, 0)), 32'h0C00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
